seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_scan_driver_if.sv | 45 ++++
 rtl/seg7_lz_mask.sv | 44 ++++
 rtl/seg7_scan_driver.sv | 127 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment types and constants for the scan driver
//
// Contents:
//   seg7_t          7-bit active-low segment pattern (bit 0 = segment a)
//   SEG7_BLANK      all segments off (7'h7F)
//   SEG7_ZERO       glyph "0" (7'h40)
//   seg7_digits_t   unpacked digit array at the default display width
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h7F;
    localparam seg7_t SEG7_ZERO  = 7'h40;

    localparam int SEG7_DEF_DIGITS = 8;

    typedef seg7_t seg7_digits_t [SEG7_DEF_DIGITS];

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display-side signal bundle of the 7-segment scanner
//
// Signals:
//   en           display enable (low = dark, scanning continues)
//   seg_in       per-digit active-low patterns, element 0 least significant
//   seg_out      active-low shared segment lines
//   an_out       active-low anode selects, one-hot-low or all-high
//   digit_idx    digit currently being scanned
//   frame_start  one-cycle pulse in cycle 0 of slot 0
// Modports:
//   master       the scan driver (consumes en/seg_in, drives the pins)
//   slave        the surrounding logic / board model
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    import seg7_pkg::*;

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic                  en;
    seg7_t                 seg_in [NUM_DIGITS];
    seg7_t                 seg_out;
    logic [NUM_DIGITS-1:0] an_out;
    logic [IDX_W-1:0]      digit_idx;
    logic                  frame_start;

    modport master (
        input  en,
        input  seg_in,
        output seg_out,
        output an_out,
        output digit_idx,
        output frame_start
    );

    modport slave (
        output en,
        output seg_in,
        input  seg_out,
        input  an_out,
        input  digit_idx,
        input  frame_start
    );

endinterface

// File: rtl/seg7_lz_mask.sv
// rtl/seg7_lz_mask.sv - registered leading-zero blank mask over a digit snapshot
//
// Used only when SEG7_LEADING_ZERO_BLANK_EN is defined.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         capture mask_next into mask (same edge as the snapshot)
//   pattern      digit patterns the mask is computed over
//   mask_next    combinational mask of pattern (bit set = digit blanked)
//   mask         registered mask, held until the next load
module seg7_lz_mask
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  seg7_t                 pattern [NUM_DIGITS],
    output logic [NUM_DIGITS-1:0] mask_next,
    output logic [NUM_DIGITS-1:0] mask
);

    logic still_leading;

    // Walk from the most significant digit down; a digit is blanked only
    // while every digit above it was a blanked "0". Digit 0 always shows.
    always_comb begin
        mask_next     = '0;
        still_leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            still_leading = still_leading && (pattern[i] == SEG7_ZERO);
            mask_next[i]  = still_leading;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
        end else if (load) begin
            mask <= mask_next;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 7-segment scanner
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (leading-zero blanking).
// Parameters:
//   NUM_DIGITS    digits scanned (>= 2)
//   CLK_DIV       clock cycles per digit slot (> BLANK_CYCLES)
//   BLANK_CYCLES  dark cycles at the start of each slot (>= 1)
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   disp          seg7_scan_driver_if.master: en, seg_in in; seg_out, an_out,
//                 digit_idx, frame_start out (all outputs straight from flops)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    seg7_scan_driver_if.master      disp
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // cnt/idx always hold the slot position of the cycle currently on the
    // pins. The first edge after reset is cycle 0 itself, so the position
    // must not advance on that edge; "running" marks that it has happened.
    logic                  running;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt_n;
    logic [IDX_W-1:0]      idx_n;

    logic                  fs_q;
    logic [NUM_DIGITS-1:0] an_q;
    seg7_t                 seg_q;
    seg7_t                 snap [NUM_DIGITS];

    logic                  blank_n;
    logic                  lz_hide;
    seg7_t                 cur_pattern;

    always_comb begin
        cnt_n = cnt;
        idx_n = idx;
        if (running) begin
            if (cnt == CNT_LAST) begin
                cnt_n = '0;
                idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    assign blank_n = (cnt_n < BLANK_END);

    // The snapshot lands on the edge that ends cycle 0 while the same edge
    // already computes cycle 1's outputs; forward seg_in there so a
    // one-cycle blank gap still shows this frame's data.
    assign cur_pattern = fs_q ? disp.seg_in[idx_n] : snap[idx_n];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] lz_mask_next;

    seg7_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .clk       (clk),
        .rst       (rst),
        .load      (fs_q),
        .pattern   (disp.seg_in),
        .mask_next (lz_mask_next),
        .mask      (lz_mask)
    );

    assign lz_hide = fs_q ? lz_mask_next[idx_n] : lz_mask[idx_n];
`else
    assign lz_hide = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            fs_q    <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG7_BLANK;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= SEG7_BLANK;
            end
        end else begin
            running <= 1'b1;
            cnt     <= cnt_n;
            idx     <= idx_n;
            fs_q    <= (cnt_n == '0) && (idx_n == '0);

            if (fs_q) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    snap[i] <= disp.seg_in[i];
                end
            end

            if (!disp.en || blank_n || lz_hide) begin
                an_q  <= '1;
                seg_q <= SEG7_BLANK;
            end else begin
                an_q  <= ~(NUM_DIGITS'(1) << idx_n);
                seg_q <= cur_pattern;
            end
        end
    end

    assign disp.seg_out     = seg_q;
    assign disp.an_out      = an_q;
    assign disp.digit_idx   = idx;
    assign disp.frame_start = fs_q;

endmodule
